// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: walks a table of I2C write words through the codec I2C master.
// Optional macro CFG_RETRY_EN enables per-command retries on NAK/timeout.
module codec_cfg_seq #(
    parameter int NUM_CMDS   = 11,
    parameter int DATA_W     = 16,
    parameter int POR_DLY    = 1024,
    parameter int GAP_CYCLES = 64,
    parameter int TIMEOUT    = 65536,
    parameter int MAX_RETRY  = 3,
    localparam int IDX_W     = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_CMDS*DATA_W-1:0] cmd_table,
    input  logic                       i2c_done,
    input  logic                       i2c_err,
    output logic [DATA_W-1:0]          cmd,
    output logic                       wrt,
    output logic                       busy,
    output logic                       cfg_done,
    output logic                       cfg_err,
    output logic [IDX_W-1:0]           err_idx
);

    localparam int CNT_A   = (POR_DLY > GAP_CYCLES) ? POR_DLY : GAP_CYCLES;
    localparam int CNT_MAX = (CNT_A > TIMEOUT) ? CNT_A : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] POR_LAST =
        CNT_W'((POR_DLY > 0) ? POR_DLY - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);

`ifdef CFG_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    logic [RTY_W-1:0] rty;
`endif

    typedef enum logic [2:0] {
        S_POR,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] tbl [NUM_CMDS];

    for (genvar i = 0; i < NUM_CMDS; i++) begin : g_tbl
        assign tbl[i] = cmd_table[i*DATA_W +: DATA_W];
    end

    // Sequencer: wrt and cmd are loaded on every entry into ISSUE so the
    // pulse lines up with the ISSUE cycle; cnt is POR delay, gap and timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_POR;
            cnt      <= '0;
            idx      <= '0;
            cmd      <= '0;
            wrt      <= 1'b0;
            busy     <= 1'b1;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_idx  <= '0;
`ifdef CFG_RETRY_EN
            rty      <= '0;
`endif
        end else begin
            wrt <= 1'b0;
            unique case (state)
                S_POR: begin
                    if (cnt == POR_LAST) begin
                        cnt   <= '0;
                        state <= S_ISSUE;
                        wrt   <= 1'b1;
                        cmd   <= tbl[idx];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    cnt   <= cnt + 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c_done && !i2c_err) begin
`ifdef CFG_RETRY_EN
                        rty <= '0;
`endif
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            if (GAP_CYCLES == 0) begin
                                state <= S_ISSUE;
                                wrt   <= 1'b1;
                                cmd   <= tbl[idx + 1'b1];
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end else if (i2c_done || cnt >= TMO_LAST) begin
                        cnt <= '0;
`ifdef CFG_RETRY_EN
                        if (rty == RTY_MAX) begin
                            state   <= S_FAIL;
                            busy    <= 1'b0;
                            cfg_err <= 1'b1;
                            err_idx <= idx;
                        end else begin
                            rty <= rty + 1'b1;
                            if (GAP_CYCLES == 0) begin
                                state <= S_ISSUE;
                                wrt   <= 1'b1;
                                cmd   <= tbl[idx];
                            end else begin
                                state <= S_GAP;
                            end
                        end
`else
                        state   <= S_FAIL;
                        busy    <= 1'b0;
                        cfg_err <= 1'b1;
                        err_idx <= idx;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= S_ISSUE;
                        wrt   <= 1'b1;
                        cmd   <= tbl[idx];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE, S_FAIL: begin
                    if (start) begin
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                        busy     <= 1'b1;
                        idx      <= '0;
                        cnt      <= '0;
`ifdef CFG_RETRY_EN
                        rty      <= '0;
`endif
                        if (GAP_CYCLES == 0) begin
                            state <= S_ISSUE;
                            wrt   <= 1'b1;
                            cmd   <= tbl[0];
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                default: begin
                    state <= S_POR;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb_codec_cfg_seq: directed bench for codec_cfg_seq with an I2C master model.
// Cycle N is the clock period following the N-th rising edge after reset release.
module tb_codec_cfg_seq;

    localparam int NC  = 4;
    localparam int DW  = 16;
    localparam int ACK = 10;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [NC*DW-1:0] cmd_table;
    logic           i2c_done;
    logic           i2c_err;
    logic [DW-1:0]  cmd;
    logic           wrt;
    logic           busy;
    logic           cfg_done;
    logic           cfg_err;
    logic [1:0]     err_idx;

    codec_cfg_seq #(
        .NUM_CMDS(NC),
        .DATA_W(DW),
        .POR_DLY(8),
        .GAP_CYCLES(4),
        .TIMEOUT(32),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cmd_table(cmd_table),
        .i2c_done(i2c_done),
        .i2c_err(i2c_err),
        .cmd(cmd),
        .wrt(wrt),
        .busy(busy),
        .cfg_done(cfg_done),
        .cfg_err(cfg_err),
        .err_idx(err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int pend = 0;
    logic err_now = 1'b0;
    int nak_used = 0;
    int nak_budget = 0;
    logic [DW-1:0] nak_cmd = '0;
    logic silent = 1'b0;
    logic force_done = 1'b0;
    int wq_cyc[$];
    logic [DW-1:0] wq_cmd[$];

    // I2C master model and wrt monitor: acks ACK clocks after each wrt
    always @(posedge clk) begin
        logic dn;
        if (!rst_n) cyc = 0;
        else cyc = cyc + 1;
        #1;
        dn = 1'b0;
        i2c_err = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                dn = 1'b1;
                i2c_err = err_now;
            end
        end
        if (rst_n && wrt) begin
            wq_cyc.push_back(cyc + 1);
            wq_cmd.push_back(cmd);
            err_now = (nak_used < nak_budget) && (cmd == nak_cmd);
            if (err_now) nak_used = nak_used + 1;
            if (!silent) pend = ACK;
        end
        i2c_done = dn | force_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_wrt(input string tag, input int base, input int n,
                            input int budget);
        int k = 0;
        while (wq_cyc.size() < base + n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(wq_cyc.size() - base >= n), 32'd1);
    endtask

    task automatic wait_lvl(input string tag, input bit use_err,
                            input int budget, output int c);
        int k = 0;
        while (((use_err ? cfg_err : cfg_done) !== 1'b1) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(use_err ? cfg_err : cfg_done), 32'd1);
        c = cyc + 1;
    endtask

    task automatic pulse_start(output int sc);
        start = 1'b1;
        sc = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int base;
        int c;
        int sc;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        cmd_table = {16'hFFFF, 16'h0C0D, 16'h0A0B, 16'h1234};

        // reset state
        repeat (3) tick();
        chk("reset flags", {28'd0, wrt, busy, cfg_done, cfg_err}, 32'h4);
        chk("reset cmd", 32'(cmd), 32'h0);
        chk("reset err_idx", 32'(err_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // nominal run
        base = wq_cyc.size();
        wait_wrt("nom 4 wrt", base, 4, 120);
        chk("nom wrt0 cyc", 32'(wq_cyc[base]), 32'd9);
        chk("nom wrt1 cyc", 32'(wq_cyc[base+1]), 32'd24);
        chk("nom wrt2 cyc", 32'(wq_cyc[base+2]), 32'd39);
        chk("nom wrt3 cyc", 32'(wq_cyc[base+3]), 32'd54);
        chk("nom cmd0", 32'(wq_cmd[base]), 32'h1234);
        chk("nom cmd1", 32'(wq_cmd[base+1]), 32'h0A0B);
        chk("nom cmd2", 32'(wq_cmd[base+2]), 32'h0C0D);
        chk("nom cmd3", 32'(wq_cmd[base+3]), 32'hFFFF);
        wait_lvl("nom done", 1'b0, 40, c);
        chk("nom done cyc", 32'(c), 32'd65);
        chk("nom busy", 32'(busy), 32'd0);
        chk("nom err", 32'(cfg_err), 32'd0);

        // restart from DONE, plus an ignored mid-run start
        base = wq_cyc.size();
        pulse_start(sc);
        chk("rst cfg_done drop", 32'(cfg_done), 32'd0);
        chk("rst busy", 32'(busy), 32'd1);
        wait_wrt("rst wrt0", base, 1, 20);
        chk("rst wrt0 lat", 32'(wq_cyc[base] - sc), 32'd5);
        chk("rst cmd0", 32'(wq_cmd[base]), 32'h1234);
        tick();
        tick();
        pulse_start(n);
        wait_wrt("rst 4 wrt", base, 4, 100);
        chk("rst wrt1 gap", 32'(wq_cyc[base+1] - wq_cyc[base]), 32'd15);
        chk("rst wrt3 gap", 32'(wq_cyc[base+3] - wq_cyc[base]), 32'd45);
        chk("rst cmd1", 32'(wq_cmd[base+1]), 32'h0A0B);
        wait_lvl("rst done", 1'b0, 40, c);
        chk("rst n wrt", 32'(wq_cyc.size() - base), 32'd4);

        // master never answers: watchdog
        silent = 1'b1;
        base = wq_cyc.size();
        pulse_start(sc);
        wait_wrt("tmo wrt0", base, 1, 20);
        wait_lvl("tmo err", 1'b1, 60, c);
        chk("tmo err lat", 32'(c - wq_cyc[base]), 32'd32);
        chk("tmo err_idx", 32'(err_idx), 32'd0);
        chk("tmo done", 32'(cfg_done), 32'd0);
        chk("tmo busy", 32'(busy), 32'd0);
        silent = 1'b0;

`ifdef CFG_RETRY_EN
        // NAK idx1 twice, then ack: three attempts and a finished run
        nak_cmd = 16'h0A0B;
        nak_budget = nak_used + 2;
        base = wq_cyc.size();
        pulse_start(sc);
        chk("rty err clr", 32'(cfg_err), 32'd0);
        wait_lvl("rty done", 1'b0, 200, c);
        chk("rty n wrt", 32'(wq_cyc.size() - base), 32'd6);
        chk("rty cmd1a", 32'(wq_cmd[base+1]), 32'h0A0B);
        chk("rty cmd1b", 32'(wq_cmd[base+2]), 32'h0A0B);
        chk("rty cmd1c", 32'(wq_cmd[base+3]), 32'h0A0B);
        chk("rty cmd2", 32'(wq_cmd[base+4]), 32'h0C0D);
        chk("rty err", 32'(cfg_err), 32'd0);
        // NAK idx1 four times: retries exhausted
        nak_budget = nak_used + 4;
        base = wq_cyc.size();
        pulse_start(sc);
        wait_lvl("rty4 err", 1'b1, 200, c);
        chk("rty4 err_idx", 32'(err_idx), 32'd1);
        chk("rty4 done", 32'(cfg_done), 32'd0);
        chk("rty4 n wrt", 32'(wq_cyc.size() - base), 32'd5);
`else
        // NAK on idx2 aborts
        nak_cmd = 16'h0C0D;
        nak_budget = nak_used + 1;
        base = wq_cyc.size();
        pulse_start(sc);
        chk("nak err clr", 32'(cfg_err), 32'd0);
        wait_wrt("nak 3 wrt", base, 3, 80);
        wait_lvl("nak err", 1'b1, 40, c);
        chk("nak err_idx", 32'(err_idx), 32'd2);
        chk("nak done", 32'(cfg_done), 32'd0);
        chk("nak busy", 32'(busy), 32'd0);
        repeat (40) tick();
        chk("nak no more wrt", 32'(wq_cyc.size() - base), 32'd3);
`endif

        // asynchronous reset during WAIT of idx2
        base = wq_cyc.size();
        pulse_start(sc);
        wait_wrt("ar 3 wrt", base, 3, 80);
        chk("ar pre cmd", 32'(cmd), 32'h0C0D);
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar flags", {28'd0, wrt, busy, cfg_done, cfg_err}, 32'h4);
        chk("ar cmd", 32'(cmd), 32'h0);
        chk("ar err_idx", 32'(err_idx), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = wq_cyc.size();
        tick();
        tick();
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        wait_wrt("ar 2 wrt", base, 2, 60);
        chk("ar wrt0 cyc", 32'(wq_cyc[base]), 32'd9);
        chk("ar cmd0", 32'(wq_cmd[base]), 32'h1234);
        chk("ar wrt1 cyc", 32'(wq_cyc[base+1]), 32'd24);
        chk("ar cmd1", 32'(wq_cmd[base+1]), 32'h0A0B);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
